aes256_ctr_framer: RTL and testbench
====================================

Name: aes256_ctr_framer

Overview:
- Upstream framing stage for the AES-256 CTR iterative core.
- Takes a per-packet configuration (256-bit key, 128-bit initial counter block, encrypt flag) and a payload AXI-Stream.
- Emits the single serialized AXI-Stream the core consumes, in this order: key words, counter words, payload words, with tlast on the final payload beat.
- The core returns to key-load after every packet, so this block re-sends key and counter for every packet.

Parameters:
- AXIS_WIDTH, 64, data width of both streams in bits. Legal values: 32, 64, 128. Must divide 128.
- KEY_WORDS, 256/AXIS_WIDTH, derived (localparam): number of key beats.
- IV_WORDS, 128/AXIS_WIDTH, derived (localparam): number of counter beats.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous, active-high reset
- Cfg_valid  in  1  configuration valid
- Cfg_ready  out  1  configuration accepted when Cfg_valid & Cfg_ready
- Cfg_key  in  256  AES-256 key; byte 0 in bits [7:0]
- Cfg_iv  in  128  initial counter block; byte 0 (most significant counter byte) in bits [7:0]
- Cfg_encrypt  in  1  encrypt flag, forwarded on tuser
- S_axis_tvalid  in  1  payload valid
- S_axis_tready  out  1  payload ready
- S_axis_tdata  in  AXIS_WIDTH  payload data
- S_axis_tkeep  in  AXIS_WIDTH/8  payload byte enables
- S_axis_tlast  in  1  last payload beat of packet
- M_axis_tvalid  out  1  framed stream valid
- M_axis_tready  in  1  framed stream ready
- M_axis_tdata  out  AXIS_WIDTH  framed data
- M_axis_tkeep  out  AXIS_WIDTH/8  framed byte enables
- M_axis_tlast  out  1  last beat of packet
- M_axis_tuser  out  1  encrypt flag, valid on every beat

Behaviour:
- Reset (Rst, synchronous, active-high; clock Clk):
  - State goes to ST_IDLE; word counter = 0.
  - M_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0.
  - Cfg_ready=0 and S_axis_tready=0 during the reset cycle.
  - A reset mid-packet drops the packet and clears the output register. No partial beat survives.
- All M_axis outputs come from a single output register.
  - Slot free = !M_axis_tvalid | M_axis_tready.
  - Once M_axis_tvalid rises, tvalid and all other M_axis fields stay stable until M_axis_tready is sampled high.
- State machine (one-hot): ST_IDLE, ST_KEY, ST_IV, ST_PAYLOAD.
  - ST_IDLE: Cfg_ready=1, S_axis_tready=0. On Cfg_valid capture key, iv and encrypt into internal registers, clear the word counter, go to ST_KEY.
  - ST_KEY: each cycle the slot is free, load beat n = Cfg_key[n*W +: W], with tkeep all ones and tlast=0. On loading n = KEY_WORDS-1, clear the counter and go to ST_IV.
  - ST_IV: same rule using Cfg_iv[n*W +: W]; low word is sent first. After beat IV_WORDS-1, go to ST_PAYLOAD.
  - ST_PAYLOAD: S_axis_tready = slot free. Each accepted beat is copied to the output register one cycle later (latency 1). The last-beat rules are given below. On an accepted beat with S_axis_tlast, go to ST_IDLE.
- Payload tkeep: non-last beats are forced to all ones. The last beat is forwarded unmodified; its tkeep must be contiguous from bit 0, and this is the source's responsibility.
- M_axis_tuser carries the captured encrypt flag on every beat of the packet, including key and counter beats.
- Cfg_ready is 0 in every state except ST_IDLE. A new configuration is accepted at the earliest one cycle after the last payload beat is accepted.
- Simultaneous events: in ST_IDLE, S_axis_tvalid is ignored (no ready). The last key beat loading and the first counter beat loading never happen in the same cycle; one beat per cycle maximum.
- Throughput: with M_axis_tready held high, one beat per cycle and no bubbles between the key, counter and payload phases. Packet overhead = KEY_WORDS + IV_WORDS + 1 (cfg) cycles.
- Empty payload packets are not supported. A packet always carries at least one payload beat.

Test Plan:
- W=64, key=0x1F1E..0100 (byte i = i), iv=0xFFEE..0x00, encrypt=1, 3 payload beats, tready=1 -> output beats 0-3 are the key low-to-high (first = 0x0706050403020100), beats 4-5 are the iv low word then high word, beats 6-8 are payload with tlast only on beat 8, tuser=1 on all 9 beats, no bubbles.
- Same packet with M_axis_tready toggling 1010... -> every output field is stable while tvalid=1 & tready=0; beat order and count are unchanged; S_axis_tready=0 whenever the slot is occupied.
- Payload last beat tkeep=0x0F, middle beat tkeep=0x00 -> middle beat is output with tkeep=0xFF; last beat is output with tkeep=0x0F and tlast=1.
- Back-to-back packets with Cfg_valid held high and a different key on the second packet -> Cfg_ready pulses once per packet only in ST_IDLE; the second packet restarts from key beat 0 with the new key; no payload is accepted between packets.
- Rst asserted during the second counter beat with tready=0 -> next cycle M_axis_tvalid=0, Cfg_ready=1 after reset release, and the next packet starts at key beat 0.
- W=32 and W=128 builds -> 8+4 and 2+1 header beats respectively, with word ordering identical to the W=64 case.

Source files
------------

// File: rtl/aes256_ctr_framer.sv
// AES-256 CTR framer: serialises per-packet key, counter block and payload
// into the single AXI-Stream consumed by the iterative CTR core.
module aes256_ctr_framer #(
  parameter int unsigned AXIS_WIDTH = 64
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Cfg_valid,
  output logic                    Cfg_ready,
  input  logic [255:0]            Cfg_key,
  input  logic [127:0]            Cfg_iv,
  input  logic                    Cfg_encrypt,
  input  logic                    S_axis_tvalid,
  output logic                    S_axis_tready,
  input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
  input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
  input  logic                    S_axis_tlast,
  output logic                    M_axis_tvalid,
  input  logic                    M_axis_tready,
  output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
  output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
  output logic                    M_axis_tlast,
  output logic                    M_axis_tuser
);

  localparam int unsigned KEY_WORDS = 256 / AXIS_WIDTH;
  localparam int unsigned IV_WORDS  = 128 / AXIS_WIDTH;
  localparam int unsigned KEEP_W    = AXIS_WIDTH / 8;
  localparam int unsigned CNT_W     = $clog2(KEY_WORDS);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WORDS - 1);
  localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_WORDS - 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_KEY     = 4'b0010,
    ST_IV      = 4'b0100,
    ST_PAYLOAD = 4'b1000
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [255:0]          key_q, key_d;
  logic [127:0]          iv_q, iv_d;
  logic                  enc_q, enc_d;
  logic                  tvalid_q, tvalid_d;
  logic [AXIS_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  cfg_rdy, s_rdy;
  logic                  slot_free;

  assign slot_free     = !tvalid_q || M_axis_tready;
  assign Cfg_ready     = cfg_rdy && !Rst;
  assign S_axis_tready = s_rdy && !Rst;
  assign M_axis_tvalid = tvalid_q;
  assign M_axis_tdata  = tdata_q;
  assign M_axis_tkeep  = tkeep_q;
  assign M_axis_tlast  = tlast_q;
  assign M_axis_tuser  = tuser_q;

  // Next-state, config capture and output-register load, one beat per cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    iv_d     = iv_q;
    enc_d    = enc_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    cfg_rdy  = 1'b0;
    s_rdy    = 1'b0;
    // A free slot empties unless a new beat is loaded below.
    if (slot_free) tvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_rdy = 1'b1;
        if (Cfg_valid) begin
          key_d   = Cfg_key;
          iv_d    = Cfg_iv;
          enc_d   = Cfg_encrypt;
          cnt_d   = '0;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tdata_d  = key_q[int'(cnt_q)*AXIS_WIDTH +: AXIS_WIDTH];
          tkeep_d  = '1;
          tlast_d  = 1'b0;
          tuser_d  = enc_q;
          if (cnt_q == KEY_LAST) begin
            cnt_d   = '0;
            state_d = ST_IV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_IV: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tdata_d  = iv_q[int'(cnt_q)*AXIS_WIDTH +: AXIS_WIDTH];
          tkeep_d  = '1;
          tlast_d  = 1'b0;
          tuser_d  = enc_q;
          if (cnt_q == IV_LAST) begin
            cnt_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        s_rdy = slot_free;
        if (slot_free && S_axis_tvalid) begin
          tvalid_d = 1'b1;
          tdata_d  = S_axis_tdata;
          tkeep_d  = S_axis_tlast ? S_axis_tkeep : '1;
          tlast_d  = S_axis_tlast;
          tuser_d  = enc_q;
          if (S_axis_tlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured config and output register; reset drops any partial packet.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      enc_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      enc_q    <= enc_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

endmodule

// File: tb/tb_aes256_ctr_framer.sv
// Directed self-checking bench for aes256_ctr_framer (W=64 main, W=32/128 header order).
module tb_aes256_ctr_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W=64 instance
  logic         cfg_valid, cfg_ready, cfg_enc;
  logic [255:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         s_valid, s_ready, s_last;
  logic [63:0]  s_data;
  logic [7:0]   s_keep;
  logic         m_valid, m_ready, m_last, m_user;
  logic [63:0]  m_data;
  logic [7:0]   m_keep;

  aes256_ctr_framer #(.AXIS_WIDTH(64)) u64 (
    .Clk(clk), .Rst(rst),
    .Cfg_valid(cfg_valid), .Cfg_ready(cfg_ready), .Cfg_key(cfg_key), .Cfg_iv(cfg_iv),
    .Cfg_encrypt(cfg_enc),
    .S_axis_tvalid(s_valid), .S_axis_tready(s_ready), .S_axis_tdata(s_data),
    .S_axis_tkeep(s_keep), .S_axis_tlast(s_last),
    .M_axis_tvalid(m_valid), .M_axis_tready(m_ready), .M_axis_tdata(m_data),
    .M_axis_tkeep(m_keep), .M_axis_tlast(m_last), .M_axis_tuser(m_user)
  );

  // W=32 and W=128 instances share key/iv/encrypt inputs
  logic [255:0] ckey;
  logic [127:0] civ;
  logic         cenc;
  logic         c32_valid, c32_ready, s32_valid, s32_ready, m32_valid, m32_last, m32_user;
  logic [31:0]  s32_data, m32_data;
  logic [3:0]   m32_keep;
  logic         c128_valid, c128_ready, s128_valid, s128_ready, m128_valid, m128_last, m128_user;
  logic [127:0] s128_data, m128_data;
  logic [15:0]  m128_keep;

  aes256_ctr_framer #(.AXIS_WIDTH(32)) u32 (
    .Clk(clk), .Rst(rst),
    .Cfg_valid(c32_valid), .Cfg_ready(c32_ready), .Cfg_key(ckey), .Cfg_iv(civ),
    .Cfg_encrypt(cenc),
    .S_axis_tvalid(s32_valid), .S_axis_tready(s32_ready), .S_axis_tdata(s32_data),
    .S_axis_tkeep(4'hF), .S_axis_tlast(1'b1),
    .M_axis_tvalid(m32_valid), .M_axis_tready(1'b1), .M_axis_tdata(m32_data),
    .M_axis_tkeep(m32_keep), .M_axis_tlast(m32_last), .M_axis_tuser(m32_user)
  );

  aes256_ctr_framer #(.AXIS_WIDTH(128)) u128 (
    .Clk(clk), .Rst(rst),
    .Cfg_valid(c128_valid), .Cfg_ready(c128_ready), .Cfg_key(ckey), .Cfg_iv(civ),
    .Cfg_encrypt(cenc),
    .S_axis_tvalid(s128_valid), .S_axis_tready(s128_ready), .S_axis_tdata(s128_data),
    .S_axis_tkeep(16'hFFFF), .S_axis_tlast(1'b1),
    .M_axis_tvalid(m128_valid), .M_axis_tready(1'b1), .M_axis_tdata(m128_data),
    .M_axis_tkeep(m128_keep), .M_axis_tlast(m128_last), .M_axis_tuser(m128_user)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]   kbytes [2][32];
  logic [255:0] key_vec [2];
  logic         enc_vec [2];
  logic [127:0] iv_vec;
  logic [63:0]  pl_data [3];
  logic [7:0]   pl_keep [3];

  logic [63:0]  od[$];
  logic [7:0]   ok[$];
  logic         ol[$], ou[$];
  int           oc[$];
  logic [31:0]  d32[$];
  logic         l32[$], u32q[$];
  logic [127:0] d128[$];
  logic         l128[$], u128q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive npkts packets (cfg held high, payload offered early) and record output beats.
  task automatic run(input int npkts, input bit toggle, input int budget);
    int acc, pay, idx, lasts, cyc;
    logic hold, pv, pl, pu;
    logic [63:0] pd;
    logic [7:0]  pk;
    od.delete(); ok.delete(); ol.delete(); ou.delete(); oc.delete();
    acc = 0; pay = 0; idx = 0; lasts = 0; cyc = 0; hold = 1'b0;
    pv = 1'b0; pl = 1'b0; pu = 1'b0; pd = '0; pk = '0;
    while (lasts < npkts && cyc < budget) begin
      cfg_valid = (acc < npkts);
      cfg_key   = key_vec[(acc < npkts) ? acc : 0];
      cfg_enc   = enc_vec[(acc < npkts) ? acc : 0];
      cfg_iv    = iv_vec;
      s_valid   = (pay < npkts);
      s_data    = pl_data[idx];
      s_keep    = pl_keep[idx];
      s_last    = (idx == 2);
      m_ready   = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", m_valid, pv);
        chk("hold_data", m_data, pd);
        chk("hold_keep", m_keep, pk);
        chk("hold_last", m_last, pl);
        chk("hold_user", m_user, pu);
      end
      if (m_valid && !m_ready) chk("s_ready_busy", s_ready, 1'b0);
      if (acc > pay) chk("cfg_ready_busy", cfg_ready, 1'b0);
      if (cfg_ready) chk("s_ready_idle", s_ready, 1'b0);
      hold = m_valid && !m_ready;
      pv = m_valid; pd = m_data; pk = m_keep; pl = m_last; pu = m_user;
      if (m_valid && m_ready) begin
        od.push_back(m_data); ok.push_back(m_keep); ol.push_back(m_last);
        ou.push_back(m_user); oc.push_back(cyc);
        if (m_last) lasts++;
      end
      if (cfg_valid && cfg_ready) acc++;
      if (s_valid && s_ready) begin
        if (s_last) begin pay++; idx = 0; end
        else idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_timeout", lasts, npkts);
    cfg_valid = 1'b0;
    s_valid   = 1'b0;
    m_ready   = 1'b1;
  endtask

  // Compare recorded W=64 beats against the byte-level model.
  task automatic verify(input int npkts, input bit timing);
    logic [63:0] e;
    int k;
    chk("beat_count", od.size(), npkts * 9);
    if (od.size() == npkts * 9) begin
      k = 0;
      for (int p = 0; p < npkts; p++) begin
        for (int j = 0; j < 9; j++) begin
          for (int b = 0; b < 8; b++) begin
            if (j < 4)      e[8*b +: 8] = kbytes[p][8*j + b];
            else if (j < 6) e[8*b +: 8] = 8'((8*(j-4) + b) * 17);
          end
          if (j >= 6) e = pl_data[j-6];
          chk($sformatf("p%0d_b%0d_data", p, j), od[k], e);
          chk($sformatf("p%0d_b%0d_keep", p, j), ok[k], (j == 8) ? pl_keep[2] : 8'hFF);
          chk($sformatf("p%0d_b%0d_last", p, j), ol[k], j == 8);
          chk($sformatf("p%0d_b%0d_user", p, j), ou[k], enc_vec[p]);
          if (timing) chk($sformatf("b%0d_cycle", j), oc[k], 2 + j);
          k++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      kbytes[0][i] = 8'(i);
      kbytes[1][i] = 8'(i) ^ 8'hC0;
      key_vec[0][8*i +: 8] = kbytes[0][i];
      key_vec[1][8*i +: 8] = kbytes[1][i];
    end
    for (int i = 0; i < 16; i++) iv_vec[8*i +: 8] = 8'(i * 17);
    enc_vec[0] = 1'b1; enc_vec[1] = 1'b0;
    pl_data[0] = 64'h1111_2222_3333_4444;
    pl_data[1] = 64'h5555_6666_7777_8888;
    pl_data[2] = 64'h9999_AAAA_BBBB_CCCC;
    pl_keep[0] = 8'hFF; pl_keep[1] = 8'hFF; pl_keep[2] = 8'hFF;

    cfg_valid = 0; cfg_key = '0; cfg_iv = '0; cfg_enc = 0;
    s_valid = 0; s_data = '0; s_keep = '0; s_last = 0; m_ready = 1;
    ckey = key_vec[0]; civ = iv_vec; cenc = 1'b0;
    c32_valid = 0; s32_valid = 0; s32_data = 32'hDEADBEEF;
    c128_valid = 0; s128_valid = 0; s128_data = 128'hCAFE0000_11112222_33334444_55556666;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1;
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_m_keep", m_keep, 8'h00);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_user", m_user, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_cfg_ready", cfg_ready, 1'b1);
    chk("idle_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;

    // Single packet, tready high: 9 beats, no bubbles
    run(1, 1'b0, 60);
    verify(1, 1'b1);
    if (od.size() >= 6) begin
      chk("key_beat0_lit", od[0], 64'h0706050403020100);
      chk("iv_lo_lit", od[4], 64'h7766554433221100);
      chk("iv_hi_lit", od[5], 64'hFFEEDDCCBBAA9988);
    end

    // Same packet with tready toggling
    run(1, 1'b1, 80);
    verify(1, 1'b0);

    // Middle tkeep 0x00 forced to all ones, last tkeep 0x0F forwarded
    pl_keep[0] = 8'h81; pl_keep[1] = 8'h00; pl_keep[2] = 8'h0F;
    run(1, 1'b0, 60);
    verify(1, 1'b1);
    pl_keep[0] = 8'hFF; pl_keep[1] = 8'hFF; pl_keep[2] = 8'hFF;

    // Back-to-back packets, cfg held high, different key and encrypt flag
    run(2, 1'b0, 100);
    verify(2, 1'b0);

    // Reset while the second counter beat is stalled
    begin
      bit found, taken;
      found = 0; taken = 0;
      cfg_valid = 1'b1; cfg_key = key_vec[1]; cfg_iv = iv_vec; cfg_enc = 1'b1; m_ready = 1'b1;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (m_valid && m_data === 64'hFFEEDDCCBBAA9988) found = 1;
        else begin
          if (cfg_valid && cfg_ready) taken = 1;
          @(posedge clk); #1;
          cfg_valid = !taken;
        end
      end
      chk("reach_iv1", found, 1'b1);
      cfg_valid = 1'b0;
      m_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_m_valid", m_valid, 1'b0);
      chk("mid_rst_m_data", m_data, 64'h0);
      chk("mid_rst_m_last", m_last, 1'b0);
      chk("mid_rst_m_user", m_user, 1'b0);
      chk("mid_rst_cfg_ready", cfg_ready, 1'b0);
      rst = 1'b0; m_ready = 1'b1;
      #1;
      chk("post_rst_cfg_ready", cfg_ready, 1'b1);
      chk("post_rst_s_ready", s_ready, 1'b0);
    end
    run(1, 1'b0, 60);
    verify(1, 1'b1);

    // W=32 and W=128 header ordering
    c32_valid = 1; c128_valid = 1; s32_valid = 1; s128_valid = 1;
    for (int c = 0; c < 30; c++) begin
      logic t32, t128, a32, a128;
      @(negedge clk);
      if (m32_valid) begin d32.push_back(m32_data); l32.push_back(m32_last); u32q.push_back(m32_user); end
      if (m128_valid) begin d128.push_back(m128_data); l128.push_back(m128_last); u128q.push_back(m128_user); end
      t32 = c32_valid && c32_ready;   t128 = c128_valid && c128_ready;
      a32 = s32_valid && s32_ready;   a128 = s128_valid && s128_ready;
      @(posedge clk); #1;
      if (t32) c32_valid = 0;
      if (t128) c128_valid = 0;
      if (a32) s32_valid = 0;
      if (a128) s128_valid = 0;
    end
    chk("w32_beats", d32.size(), 13);
    chk("w128_beats", d128.size(), 4);
    if (d32.size() == 13) begin
      chk("w32_key0_lit", d32[0], 32'h03020100);
      chk("w32_iv0_lit", d32[8], 32'h33221100);
      for (int j = 0; j < 12; j++) begin
        logic [31:0] e;
        for (int b = 0; b < 4; b++)
          e[8*b +: 8] = (j < 8) ? 8'(4*j + b) : 8'((4*(j-8) + b) * 17);
        chk($sformatf("w32_b%0d", j), d32[j], e);
        chk($sformatf("w32_b%0d_last", j), l32[j], 1'b0);
      end
      chk("w32_payload", d32[12], 32'hDEADBEEF);
      chk("w32_payload_last", l32[12], 1'b1);
      chk("w32_user", u32q[3], 1'b0);
    end
    if (d128.size() == 4) begin
      chk("w128_key0", d128[0], 128'h0F0E0D0C0B0A09080706050403020100);
      chk("w128_key1", d128[1], 128'h1F1E1D1C1B1A19181716151413121110);
      chk("w128_iv", d128[2], 128'hFFEEDDCCBBAA99887766554433221100);
      chk("w128_iv_last", l128[2], 1'b0);
      chk("w128_payload", d128[3], 128'hCAFE0000_11112222_33334444_55556666);
      chk("w128_payload_last", l128[3], 1'b1);
      chk("w128_user", u128q[0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
